// File: rtl/csr_file.sv
// Machine-mode Zicsr register file: combinational CSR read/legality check,
// edge-committed writes, trap entry/mret sequencing and 64-bit cycle/instret counters.
module csr_file #(
    parameter int          XLEN        = 32,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [63:0] HART_ID     = 64'd0,
    parameter logic [63:0] RESET_VEC   = 64'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [2:0]      func3,
    input  logic [4:0]      rs1,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [11:0]     csr_addr,
    input  logic            instr_retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret,
    output logic [XLEN-1:0] rd_val,
    output logic            illegal_csr,
    output logic [1:0]      priv_mode,
    output logic [XLEN-1:0] mtvec_q,
    output logic [XLEN-1:0] mepc_q,
    output logic            mie_q
);

    localparam int NS = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam logic [XLEN-1:0] MTVEC_RST = {RESET_VEC[XLEN-1:2], 2'b00};

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    logic [1:0]      priv_q;
    logic            mie;
    logic            mpie;
    logic [1:0]      mpp;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;
    logic [63:0]     mcycle_d;
    logic [63:0]     minstret_d;
    logic [XLEN-1:0] scratch [NS];

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] wval;
    logic            hit;
    logic            writes;
    logic            read_only;
    logic            priv_fail;
    logic            func3_bad;
    logic            illegal;
    logic            do_write;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[3]     = mie;
        mstatus_val[7]     = mpie;
        mstatus_val[12:11] = mpp;
    end

    // High counter halves only exist as separate CSRs on RV32.
    always_comb begin
        old_val = '0;
        hit     = 1'b0;
        case (csr_addr)
            12'h300: begin old_val = mstatus_val; hit = 1'b1; end
            12'h305: begin old_val = mtvec;       hit = 1'b1; end
            12'h340: begin old_val = mscratch;    hit = 1'b1; end
            12'h341: begin old_val = mepc;        hit = 1'b1; end
            12'h342: begin old_val = mcause;      hit = 1'b1; end
            12'h343: begin old_val = mtval;       hit = 1'b1; end
            12'hB00, 12'hC00: begin
                old_val = mcycle[XLEN-1:0];
                hit     = 1'b1;
            end
            12'hB02, 12'hC02: begin
                old_val = minstret[XLEN-1:0];
                hit     = 1'b1;
            end
            12'hB80, 12'hC80: begin
                if (XLEN == 32) begin
                    old_val = XLEN'(mcycle[63:32]);
                    hit     = 1'b1;
                end
            end
            12'hB82, 12'hC82: begin
                if (XLEN == 32) begin
                    old_val = XLEN'(minstret[63:32]);
                    hit     = 1'b1;
                end
            end
            12'hF14: begin old_val = HART_ID[XLEN-1:0]; hit = 1'b1; end
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (csr_addr == 12'h7C0 + 12'(i)) begin
                        old_val = scratch[i];
                        hit     = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        src       = func3[2] ? XLEN'(rs1) : rs1_val;
        writes    = (func3[1:0] == 2'b01) || (rs1 != 5'd0);
        read_only = (csr_addr[11:10] == 2'b11);
        priv_fail = (csr_addr[9:8] > priv_q);
        func3_bad = (func3[1:0] == 2'b00);
        illegal   = csr_valid && (priv_fail || !hit || func3_bad || (read_only && writes));
        do_write  = csr_valid && !illegal && writes && !trap_valid && !mret;
        case (func3[1:0])
            2'b10:   wval = old_val | src;
            2'b11:   wval = old_val & ~src;
            default: wval = src;
        endcase
    end

    assign rd_val      = illegal ? '0 : old_val;
    assign illegal_csr = illegal;
    assign priv_mode   = priv_q;
    assign mtvec_q     = mtvec;
    assign mepc_q      = mepc;
    assign mie_q       = mie;

    // A software write to any half of a counter suppresses that counter's increment.
    always_comb begin
        mcycle_d   = mcycle + 64'd1;
        minstret_d = minstret + 64'(instr_retire);
        if (do_write) begin
            case (csr_addr)
                12'hB00: mcycle_d   = (XLEN == 32) ? {mcycle[63:32], wval[31:0]} : 64'(wval);
                12'hB02: minstret_d = (XLEN == 32) ? {minstret[63:32], wval[31:0]} : 64'(wval);
                12'hB80: mcycle_d   = {wval[31:0], mcycle[31:0]};
                12'hB82: minstret_d = {wval[31:0], minstret[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            priv_q   <= PRIV_M;
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mpp      <= PRIV_U;
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mcycle   <= '0;
            minstret <= '0;
            for (int i = 0; i < NS; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            mcycle   <= mcycle_d;
            minstret <= minstret_d;
            if (trap_valid) begin
                mepc   <= {trap_pc[XLEN-1:2], 2'b00};
                mcause <= trap_cause;
                mtval  <= trap_val;
                mpie   <= mie;
                mie    <= 1'b0;
                mpp    <= priv_q;
                priv_q <= PRIV_M;
            end else if (mret) begin
                priv_q <= mpp;
                mie    <= mpie;
                mpie   <= 1'b1;
                mpp    <= PRIV_U;
            end else if (do_write) begin
                case (csr_addr)
                    12'h300: begin
                        mie  <= wval[3];
                        mpie <= wval[7];
                        mpp  <= (wval[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
                    end
                    12'h305: mtvec    <= {wval[XLEN-1:2], 2'b00};
                    12'h340: mscratch <= wval;
                    12'h341: mepc     <= {wval[XLEN-1:2], 2'b00};
                    12'h342: mcause   <= wval;
                    12'h343: mtval    <= wval;
                    default: ;
                endcase
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (csr_addr == 12'h7C0 + 12'(i)) begin
                        scratch[i] <= wval;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file (RV32, 4 scratch CSRs): expectations are queued as
// each step is driven and compared on the following falling edge.
module tb_csr_file;

    localparam int XLEN = 32;

    localparam logic [2:0] RW  = 3'b001;
    localparam logic [2:0] RS  = 3'b010;
    localparam logic [2:0] RC  = 3'b011;
    localparam logic [2:0] RSI = 3'b110;
    localparam logic [2:0] RCI = 3'b111;

    localparam int SEL_RD   = 0;
    localparam int SEL_ILL  = 1;
    localparam int SEL_PRIV = 2;
    localparam int SEL_MEPC = 3;
    localparam int SEL_MIE  = 4;
    localparam int SEL_TVEC = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            csr_valid = 1'b0;
    logic [2:0]      func3 = '0;
    logic [4:0]      rs1 = '0;
    logic [XLEN-1:0] rs1_val = '0;
    logic [11:0]     csr_addr = '0;
    logic            instr_retire = 1'b0;
    logic            trap_valid = 1'b0;
    logic [XLEN-1:0] trap_pc = '0;
    logic [XLEN-1:0] trap_cause = '0;
    logic [XLEN-1:0] trap_val = '0;
    logic            mret = 1'b0;
    logic [XLEN-1:0] rd_val;
    logic            illegal_csr;
    logic [1:0]      priv_mode;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic            mie_q;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          pass_count = 0;
    int          fail_count = 0;
    logic [63:0] cyc_model = '0;

    csr_file #(
        .XLEN(XLEN),
        .NUM_SCRATCH(4),
        .HART_ID(64'd5),
        .RESET_VEC(64'h1003)
    ) dut (
        .clk(clk),
        .rst(rst),
        .csr_valid(csr_valid),
        .func3(func3),
        .rs1(rs1),
        .rs1_val(rs1_val),
        .csr_addr(csr_addr),
        .instr_retire(instr_retire),
        .trap_valid(trap_valid),
        .trap_pc(trap_pc),
        .trap_cause(trap_cause),
        .trap_val(trap_val),
        .mret(mret),
        .rd_val(rd_val),
        .illegal_csr(illegal_csr),
        .priv_mode(priv_mode),
        .mtvec_q(mtvec_q),
        .mepc_q(mepc_q),
        .mie_q(mie_q)
    );

    always #5 clk = ~clk;

    // Reference cycle count: every non-reset edge adds one.
    always @(posedge clk) begin
        if (rst) cyc_model <= '0;
        else     cyc_model <= cyc_model + 64'd1;
    end

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_RD:   return 64'(rd_val);
            SEL_ILL:  return 64'(illegal_csr);
            SEL_PRIV: return 64'(priv_mode);
            SEL_MEPC: return 64'(mepc_q);
            SEL_MIE:  return 64'(mie_q);
            SEL_TVEC: return 64'(mtvec_q);
            default:  return 64'hX;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] f, input logic [4:0] r, input logic [31:0] v,
                                 input logic [11:0] a, input logic [31:0] exp_rd,
                                 input logic exp_ill, input string tag);
        csr_valid = 1'b1;
        func3     = f;
        rs1       = r;
        rs1_val   = v;
        csr_addr  = a;
        sb.push_back('{{tag, ".rd"}, SEL_RD, 64'(exp_rd)});
        sb.push_back('{{tag, ".ill"}, SEL_ILL, 64'(exp_ill)});
    endtask

    task automatic expectState(input int sel, input logic [63:0] v, input string tag);
        sb.push_back('{tag, sel, v});
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [63:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) pass_count++;
            else begin
                fail_count++;
                $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
            end
        end
        @(posedge clk);
        #1;
        csr_valid    = 1'b0;
        trap_valid   = 1'b0;
        mret         = 1'b0;
        instr_retire = 1'b0;
        func3        = '0;
        rs1          = '0;
        rs1_val      = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        expectState(SEL_PRIV, 64'd3, "rst_priv");
        expectState(SEL_TVEC, 64'h1000, "rst_mtvec");
        expectState(SEL_MEPC, 64'd0, "rst_mepc");
        expectState(SEL_MIE, 64'd0, "rst_mie");
        expectState(SEL_ILL, 64'd0, "rst_ill_idle");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h305, 32'h1000, 1'b0, "rd_mtvec");
        checkOutput();

        applyStimulus(RW, 5'd1, 32'hDEADBEEF, 12'h340, 32'h0, 1'b0, "rw_mscratch");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'hFFFF, 12'h340, 32'hDEADBEEF, 1'b0, "rs0_mscratch");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h340, 32'hDEADBEEF, 1'b0, "rs0_nowrite");
        checkOutput();

        applyStimulus(RW, 5'd2, 32'h12345678, 12'h7C3, 32'h0, 1'b0, "rw_scr3");
        checkOutput();
        applyStimulus(RC, 5'd1, 32'h0000FF00, 12'h7C3, 32'h12345678, 1'b0, "rc_scr3");
        checkOutput();
        applyStimulus(RSI, 5'd5, 32'h0, 12'h7C3, 32'h12340078, 1'b0, "rsi_scr3");
        checkOutput();
        applyStimulus(RCI, 5'd5, 32'h0, 12'h7C3, 32'h1234007D, 1'b0, "rci_scr3");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h7C3, 32'h12340078, 1'b0, "rd_scr3");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h7C0, 32'h0, 1'b0, "rd_scr0");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h7C4, 32'h0, 1'b1, "scr4_unimpl");
        checkOutput();

        applyStimulus(RW, 5'd1, 32'h1088, 12'h300, 32'h0, 1'b0, "rw_mstatus");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h300, 32'h88, 1'b0, "mpp_warl");
        checkOutput();
        mret = 1'b1;
        checkOutput();
        expectState(SEL_PRIV, 64'd0, "mret_to_u");
        expectState(SEL_MIE, 64'd1, "mret_mie");
        checkOutput();

        applyStimulus(RS, 5'd0, 32'h0, 12'h300, 32'h0, 1'b1, "u_rd_mstatus");
        checkOutput();
        applyStimulus(RW, 5'd1, 32'h0, 12'h300, 32'h0, 1'b1, "u_wr_mstatus");
        checkOutput();
        expectState(SEL_MIE, 64'd1, "u_wr_nochange");
        applyStimulus(RS, 5'd0, 32'h0, 12'hC00, cyc_model[31:0], 1'b0, "u_rd_cycle");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'hB00, 32'h0, 1'b1, "u_rd_mcycle");
        checkOutput();

        trap_valid = 1'b1;
        trap_pc    = 32'h103;
        trap_cause = 32'd2;
        trap_val   = 32'hBAD;
        checkOutput();
        expectState(SEL_PRIV, 64'd3, "trap_priv");
        expectState(SEL_MEPC, 64'h100, "trap_mepc");
        expectState(SEL_MIE, 64'd0, "trap_mie");
        applyStimulus(RS, 5'd0, 32'h0, 12'h300, 32'h80, 1'b0, "trap_mstatus");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h342, 32'd2, 1'b0, "trap_mcause");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h343, 32'hBAD, 1'b0, "trap_mtval");
        checkOutput();
        mret = 1'b1;
        checkOutput();
        expectState(SEL_PRIV, 64'd0, "mret2_priv");
        expectState(SEL_MIE, 64'd1, "mret2_mie");
        trap_valid = 1'b1;
        trap_pc    = 32'h200;
        trap_cause = 32'd8;
        checkOutput();
        expectState(SEL_PRIV, 64'd3, "trap2_priv");
        expectState(SEL_MEPC, 64'h200, "trap2_mepc");
        checkOutput();

        trap_valid = 1'b1;
        trap_pc    = 32'h304;
        applyStimulus(RW, 5'd1, 32'h40, 12'h341, 32'h200, 1'b0, "trap_wr_mepc");
        checkOutput();
        expectState(SEL_MEPC, 64'h304, "trap_beats_wr");
        applyStimulus(RS, 5'd0, 32'h0, 12'h300, 32'h1800, 1'b0, "trap_from_m");
        checkOutput();
        mret = 1'b1;
        applyStimulus(RW, 5'd1, 32'h1, 12'h340, 32'hDEADBEEF, 1'b0, "mret_wr");
        checkOutput();
        expectState(SEL_PRIV, 64'd3, "mret_to_m");
        expectState(SEL_MIE, 64'd0, "mret3_mie");
        applyStimulus(RS, 5'd0, 32'h0, 12'h340, 32'hDEADBEEF, 1'b0, "mret_drop_wr");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h300, 32'h80, 1'b0, "mret3_mstatus");
        checkOutput();

        applyStimulus(RW, 5'd1, 32'h1, 12'hC00, 32'h0, 1'b1, "wr_cycle_ro");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'hF14, 32'd5, 1'b0, "rd_hartid");
        checkOutput();
        applyStimulus(RSI, 5'd1, 32'h0, 12'hF14, 32'h0, 1'b1, "rsi_hartid");
        checkOutput();
        applyStimulus(3'b000, 5'd0, 32'h0, 12'h340, 32'h0, 1'b1, "func3_000");
        checkOutput();
        applyStimulus(3'b100, 5'd0, 32'h0, 12'h340, 32'h0, 1'b1, "func3_100");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h7FF, 32'h0, 1'b1, "unimpl");
        checkOutput();
        applyStimulus(RW, 5'd1, 32'h1237, 12'h341, 32'h304, 1'b0, "rw_mepc");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h341, 32'h1234, 1'b0, "mepc_align");
        checkOutput();
        applyStimulus(RW, 5'd1, 32'h2003, 12'h305, 32'h1000, 1'b0, "rw_mtvec");
        checkOutput();
        expectState(SEL_TVEC, 64'h2000, "mtvec_align");
        checkOutput();

        applyStimulus(RW, 5'd1, 32'hFFFFFFFF, 12'hB00, cyc_model[31:0], 1'b0, "wr_mcycle");
        checkOutput();
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'hB00, 32'h0, 1'b0, "mcycle_wrap");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'hB80, 32'h1, 1'b0, "mcycleh_carry");
        checkOutput();
        applyStimulus(RW, 5'd1, 32'h7, 12'hB80, 32'h1, 1'b0, "wr_mcycleh");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'hC80, 32'h7, 1'b0, "rd_cycleh");
        checkOutput();
        instr_retire = 1'b1;
        applyStimulus(RW, 5'd1, 32'h5, 12'hB02, 32'h0, 1'b0, "wr_minstret");
        checkOutput();
        instr_retire = 1'b1;
        applyStimulus(RS, 5'd0, 32'h0, 12'hC02, 32'h5, 1'b0, "instret_wr_wins");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'hB02, 32'h6, 1'b0, "instret_inc");
        checkOutput();

        rst        = 1'b1;
        trap_valid = 1'b1;
        trap_pc    = 32'h500;
        applyStimulus(RW, 5'd1, 32'h55, 12'h340, 32'hDEADBEEF, 1'b0, "rst_with_trap");
        checkOutput();
        rst = 1'b0;
        expectState(SEL_PRIV, 64'd3, "rst2_priv");
        expectState(SEL_MEPC, 64'd0, "rst2_mepc");
        expectState(SEL_TVEC, 64'h1000, "rst2_mtvec");
        applyStimulus(RS, 5'd0, 32'h0, 12'h340, 32'h0, 1'b0, "rst2_mscratch");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'h7C3, 32'h0, 1'b0, "rst2_scr3");
        checkOutput();
        applyStimulus(RS, 5'd0, 32'h0, 12'hB80, 32'h0, 1'b0, "rst2_mcycleh");
        checkOutput();

        $display("%0d/%0d checks passed", pass_count, checks);
        $finish;
    end

endmodule
